// File: rtl/spike_rate_display_if.sv
// -----------------------------------------------------------------------------
// spike_rate_display_if
//
// Purpose : Bundles the data path of the spike-rate display. The classifier bit
//           goes in, and the latched rate plus its 7-segment pattern come out.
//
// Signals :
//   spike_in    1  classifier output, synchronous to the block clock
//   rate_out    4  edge count of the last completed window, saturated at 15
//   rate_valid  1  one-cycle pulse when rate_out has just been updated
//   seg_out     8  active-high segments, bit0=a .. bit6=g, bit7=dp
//
// Modports:
//   master : drives spike_in and observes the display (classifier / bench side)
//   slave  : consumes spike_in and drives the display (spike_rate_display)
// -----------------------------------------------------------------------------
interface spike_rate_display_if;
  logic       spike_in;
  logic [3:0] rate_out;
  logic       rate_valid;
  logic [7:0] seg_out;

  modport master (
    output spike_in,
    input  rate_out,
    input  rate_valid,
    input  seg_out
  );

  modport slave (
    input  spike_in,
    output rate_out,
    output rate_valid,
    output seg_out
  );
endinterface : spike_rate_display_if

// File: rtl/spike_rate_display.sv
// -----------------------------------------------------------------------------
// spike_rate_display
//
// Purpose : Counts rising edges of the perceptron classification bit over a
//           fixed window of WINDOW_CYCLES clocks. At each window boundary it
//           latches the count, saturated to 4 bits, and shows it as a hex
//           digit on a 7-segment display.
//
// Parameters:
//   WINDOW_CYCLES  window length in clocks, legal range 2 .. 2^24-1
//
// Ports:
//   clk    input   clock
//   rst_n  input   asynchronous active-low reset
//   bus    slave   spike_in in; rate_out, rate_valid, seg_out out
//
// Build option:
//   SPIKE_RATE_OVF_DP_EN  when defined, an overflow flag is kept and drives
//                         the decimal point (seg_out[7]). This happens when
//                         the last window had more than 15 edges. When it is
//                         not defined, the dp is tied low and the flag is
//                         not built.
//
// The block has a single running state and no FSM. Counting starts on the
// first clock after reset release, with the window counter at 0.
// -----------------------------------------------------------------------------
module spike_rate_display #(
  parameter logic [23:0] WINDOW_CYCLES = 24'd10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spike_rate_display_if.slave   bus
);

  localparam logic [23:0] LAST_CYCLE = WINDOW_CYCLES - 24'd1;

  logic        prev_q;
  logic [23:0] wcnt_q, wcnt_d;
  logic [4:0]  acc_q, acc_d;
  logic [3:0]  rate_q, rate_d;
  logic        rate_valid_q;

  logic        spike_edge;
  logic        terminal;
  logic [4:0]  closing_count;
  logic [6:0]  seg7;
  logic        dp;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    spike_edge    = bus.spike_in & ~prev_q;
    terminal      = (wcnt_q == LAST_CYCLE);
    // acc saturates at 16, so acc + edge is at most 17 and fits in 5 bits.
    closing_count = acc_q + {4'd0, spike_edge};

    wcnt_d = wcnt_q + 24'd1;
    acc_d  = acc_q;
    rate_d = rate_q;

    if (terminal) begin
      // An edge on the terminal cycle belongs to the window that is closing.
      wcnt_d = '0;
      acc_d  = '0;
      rate_d = (closing_count > 5'd15) ? 4'hF : closing_count[3:0];
    end else if (spike_edge && (acc_q < 5'd16)) begin
      acc_d = acc_q + 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together from values sampled before the edge.
    if (!rst_n) begin
      prev_q       <= 1'b0;
      wcnt_q       <= '0;
      acc_q        <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
    end else begin
      prev_q       <= bus.spike_in;
      wcnt_q       <= wcnt_d;
      acc_q        <= acc_d;
      rate_q       <= rate_d;
      rate_valid_q <= terminal;
    end
  end

`ifdef SPIKE_RATE_OVF_DP_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (terminal) begin
      ovf_q <= (closing_count > 5'd15);
    end
  end

  assign dp = ovf_q;
`else
  assign dp = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Hex to 7-segment decode. It is driven from the rate register, so the digit
  // holds steady between window updates.
  // ---------------------------------------------------------------------------
  always_comb begin
    seg7 = 7'h3F;
    case (rate_q)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      4'hF: seg7 = 7'h71;
      default: seg7 = 7'h3F;
    endcase
  end

  assign bus.rate_out   = rate_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.seg_out    = {dp, seg7};

endmodule : spike_rate_display

// File: tb/tb_spike_rate_display.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_display
//
// Two instances run side by side: dut_a with a 16-cycle window and dut_b with
// a 64-cycle window. The driver keeps, for each instance, the list of
// spike_in samples of the current window. When a window fills, the driver
// counts 0->1 transitions in that list and pushes the expected display into
// a queue. A monitor pops one entry for every rate_valid pulse. Between
// pulses it checks that the display holds its last value, and it checks the
// reset values while rst_n is low. Build with +define+SPIKE_RATE_OVF_DP_EN
// for the decimal-point variant.
// -----------------------------------------------------------------------------
module tb_spike_rate_display;

  localparam int W_A = 16;
  localparam int W_B = 64;
`ifdef SPIKE_RATE_OVF_DP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [3:0] rate;
    logic [7:0] seg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   mon_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];
  bit   win_a[$];
  bit   win_b[$];
  bit   prev_a = 1'b0;
  bit   prev_b = 1'b0;

  logic [3:0] hold_rate [2];
  logic [7:0] hold_seg  [2];

  spike_rate_display_if if_a ();
  spike_rate_display_if if_b ();

  spike_rate_display #(.WINDOW_CYCLES(24'd16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  spike_rate_display #(.WINDOW_CYCLES(24'd64)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int count_edges(input bit p, input bit q[$]);
    int n = 0;
    bit last = p;
    foreach (q[i]) begin
      if (q[i] && !last) n++;
      last = q[i];
    end
    return n;
  endfunction

  function automatic exp_t make_exp(input int n);
    exp_t e;
    e.rate = (n > 15) ? 4'hF : 4'(n);
    e.seg  = {(OVF_EN && (n > 15)), HEX[e.rate]};
    return e;
  endfunction

  task automatic model_a(input bit s);
    int n;
    win_a.push_back(s);
    if (win_a.size() == W_A) begin
      n = count_edges(prev_a, win_a);
      prev_a = win_a[W_A-1];
      win_a.delete();
      exp_a.push_back(make_exp(n));
    end
  endtask

  task automatic model_b(input bit s);
    int n;
    win_b.push_back(s);
    if (win_b.size() == W_B) begin
      n = count_edges(prev_b, win_b);
      prev_b = win_b[W_B-1];
      win_b.delete();
      exp_b.push_back(make_exp(n));
    end
  endtask

  function automatic bit rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // Called at a falling edge. It drives one sample per instance, records the
  // sample in the model, and advances to the next falling edge.
  task automatic step(input bit sa, input bit sb);
    if_a.spike_in = sa;
    if_b.spike_in = sb;
    model_a(sa);
    model_b(sb);
    @(negedge clk);
  endtask

  // Asserts reset at a falling edge and toggles spike_in while reset is held.
  // Releases reset at a later falling edge, so the next step() drives cycle 0.
  task automatic do_reset(input int cycles);
    check("a_drained_before_reset", exp_a.size(), 0);
    check("b_drained_before_reset", exp_b.size(), 0);
    rst_n = 1'b0;
    mon_en = 1'b1;
    exp_a.delete(); exp_b.delete();
    win_a.delete(); win_b.delete();
    prev_a = 1'b0; prev_b = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if_a.spike_in = i[0];
      if_b.spike_in = ~i[0];
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int id, input logic v, input logic [3:0] r, input logic [7:0] s);
    exp_t e;
    string nm;
    bit empty;
    nm = (id == 0) ? "a" : "b";
    if (!rst_n) begin
      check({nm, "_reset_rate"}, r, 0);
      check({nm, "_reset_seg"}, s, 8'h3F);
      check({nm, "_reset_valid"}, v, 0);
      hold_rate[id] = 4'h0;
      hold_seg[id]  = 8'h3F;
      return;
    end
    if (v) begin
      empty = (id == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
      if (empty) begin
        check({nm, "_unexpected_valid"}, v, 0);
      end else begin
        if (id == 0) e = exp_a.pop_front();
        else         e = exp_b.pop_front();
        check({nm, "_rate"}, r, e.rate);
        check({nm, "_seg"}, s, e.seg);
        hold_rate[id] = e.rate;
        hold_seg[id]  = e.seg;
      end
    end else begin
      check({nm, "_hold_rate"}, r, hold_rate[id]);
      check({nm, "_hold_seg"}, s, hold_seg[id]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        mon(0, if_a.rate_valid, if_a.rate_out, if_a.seg_out);
        mon(1, if_b.rate_valid, if_b.rate_out, if_b.seg_out);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int dens;
    if_a.spike_in = 1'b0;
    if_b.spike_in = 1'b0;
    hold_rate[0] = 4'h0; hold_rate[1] = 4'h0;
    hold_seg[0] = 8'h3F; hold_seg[1] = 8'h3F;
    @(negedge clk);

    // dut_a: pulses at 2,5,9, then an edge on a terminal cycle (31), then an
    // edge on a window's cycle 0 (48), then a level held across boundaries
    // (65..100).
    do_reset(6);
    for (int c = 0; c < 104; c++) begin
      step((c == 2) || (c == 5) || (c == 9) || (c == 31) || (c == 48) ||
           ((c >= 65) && (c <= 100)), rnd(40));
    end

    // Reset mid-window. The partial count of 4 edges must be discarded, and
    // the next update must come 16 cycles after release.
    do_reset(4);
    for (int c = 0; c < 10; c++) begin
      step((c == 1) || (c == 3) || (c == 5) || (c == 7), rnd(30));
    end
    do_reset(3);
    for (int c = 0; c < 40; c++) begin
      step((c == 4) || (c == 6), rnd(30));
    end

    // dut_b: 20 edges in one window saturate the count at 15, then 2 edges.
    do_reset(2);
    for (int c = 0; c < 128; c++) begin
      step(rnd(50), (c < 40) ? (c % 2 == 0) : ((c == 70) || (c == 90)));
    end

    // Random density per 64-cycle block on both instances.
    do_reset(3);
    for (int k = 0; k < 30; k++) begin
      dens = int'($urandom_range(0, 100));
      for (int c = 0; c < 64; c++) step(rnd(dens), rnd(dens));
    end

    if_a.spike_in = 1'b0;
    if_b.spike_in = 1'b0;
    repeat (2) @(negedge clk);
    check("a_all_windows_reported", exp_a.size(), 0);
    check("b_all_windows_reported", exp_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_spike_rate_display

// File: doc/spike_rate_display.md
# spike_rate_display

Downstream consumer of the perceptron's `classification` bit. It counts rising edges of the classification output over a fixed window of clock cycles. At each window boundary it latches the count, saturated to 4 bits, and drives it as a hex digit on the 7-segment outputs (`uo_out`). This turns the 1-bit classifier into a human-readable firing-rate readout on the board display.

## Interface
- `WINDOW_CYCLES`, 24'd10_000_000, window length in clock cycles; legal range 2..2^24-1.
- `clk`  input  1  clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `spike_in`  input  1  perceptron classification bit, synchronous to `clk`.
- `rate_out`  output  4  latched edge count of the last completed window, saturated at 15.
- `rate_valid`  output  1  one-cycle pulse when `rate_out` has just been updated.
- `seg_out`  output  8  active-high segments; bit0=a … bit6=g, bit7=dp.

## Operation
- Reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- Edge detect:
  - A `prev` register holds last cycle's `spike_in`; reset value 0.
  - An edge is `spike_in & ~prev`.
  - A level held high counts once only.
- Window counter `wcnt`, 24 bits:
  - Runs 0..WINDOW_CYCLES-1, then wraps to 0.
  - The terminal cycle is `wcnt == WINDOW_CYCLES-1`.
- Accumulator `acc`:
  - 5 bits, saturating at 16 or above.
  - On a non-terminal cycle it increments when an edge is present.
- Terminal cycle:
  - `rate_out` <= min(acc + edge, 15). An edge on the terminal cycle belongs to the closing window.
  - `acc` <= 0.
  - `rate_valid` <= 1 for the next cycle only.
  - The overflow flag `ovf` <= (acc + edge > 15).
- Segment decode:
  - Combinational from the `rate_out` register.
  - Hex codes 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- States: a single running state with no idle state. Counting starts on the first clock after reset release.

## Timing
- Reset values: `rate_out`=0, `rate_valid`=0, `seg_out`=8'h3F, `ovf`=0, `acc`=0, `wcnt`=0, `prev`=0.
- Reset is asynchronous. Asserting it mid-window discards the partial count. The first post-release cycle is `wcnt`=0.
- The first `rate_valid` occurs WINDOW_CYCLES cycles after reset release: registered at the end of cycle WINDOW_CYCLES-1, visible at cycle WINDOW_CYCLES.
- Update latency: `rate_out`, `seg_out` and `rate_valid` change together, one clock after the terminal cycle.
- Between updates, `rate_out` and `seg_out` hold steady.
- Edge-detect latency: an edge is counted in the same cycle `spike_in` rises, with no extra pipeline.
- Edge on cycle `wcnt`=0 of a new window: counted in the new window.
- `spike_in` high across a boundary: not recounted in the new window.

## Configuration
- `SPIKE_RATE_OVF_DP_EN` defined:
  - `seg_out[7]` = `ovf`. The decimal point lights when the last window had more than 15 edges.
  - `ovf` is updated every terminal cycle.
- Not defined:
  - `seg_out[7]` tied 0.
  - The `ovf` register is not built.
  - Saturation of `rate_out` at 15 is unchanged.

## Test plan
- Reset: hold `rst_n`=0 with `spike_in` toggling → `rate_out`=0, `seg_out`=8'h3F, `rate_valid`=0 throughout.
- `WINDOW_CYCLES`=16, three 1-cycle pulses at cycles 2, 5, 9 → at cycle 16: `rate_out`=3, `seg_out`=8'h4F, `rate_valid` high for exactly one cycle.
- `WINDOW_CYCLES`=16, `spike_in` held high from cycle 1 through the next two windows → first window `rate_out`=1, second window `rate_out`=0.
- `WINDOW_CYCLES`=64, 20 edges in one window → `rate_out`=15, `seg_out`=8'h71 with `SPIKE_RATE_OVF_DP_EN` undefined, or 8'hF1 with it defined. The next window has 2 edges → `rate_out`=2, dp=0.
- `WINDOW_CYCLES`=16:
  - Single edge on cycle 15 → `rate_out`=1 at cycle 16.
  - Then a single edge on cycle 16 (new window `wcnt`=0) → `rate_out`=1 at cycle 32, not 0 or 2.
- `WINDOW_CYCLES`=16, 4 edges, then `rst_n` pulsed low at cycle 10 → no `rate_valid` at cycle 16. The next `rate_valid` comes 16 cycles after release with the count of post-release edges only.
